nabp_shift_sequencer: RTL

Generates the shifter-side control protocol consumed by the projection-line mapper: one sh_kick pulse, then a run of sh_shift_en strobes (one per image column), then one sh_done pulse. It sits between the top-level state control and the mapper/line-buffer datapath. It starts one projection-line sweep per start request, and honours back-pressure from the processing-element array by withholding shift strobes.

---
 rtl/nabp_shift_sequencer.sv | 102 ++++++++++
 1 files changed

// File: rtl/nabp_shift_sequencer.sv
// Shifter-side sweep sequencer: one sh_kick, IMAGE_SIZE sh_shift_en strobes, then one sh_done.
// Latency: kick in the cycle after ss_start is sampled; first strobe FILL_DELAY cycles after kick.
// Backpressure: ss_stall withholds sh_shift_en combinationally and freezes the column count.
module nabp_shift_sequencer #(
    parameter int IMAGE_SIZE = 128,
    parameter int FILL_DELAY = 2,
    parameter int COUNT_W    = $clog2(IMAGE_SIZE)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ss_start,
    input  logic               ss_stall,
    output logic               sh_kick,
    output logic               sh_shift_en,
    output logic               sh_done,
    output logic               sh_busy,
    output logic [COUNT_W-1:0] sh_count
);

    localparam int FILL_W = (FILL_DELAY > 2) ? $clog2(FILL_DELAY) : 1;
    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'((FILL_DELAY >= 2) ? FILL_DELAY - 2 : 0);
    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(IMAGE_SIZE - 1);

    typedef enum logic [2:0] {
        ST_READY,
        ST_KICK,
        ST_FILL,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic [COUNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_READY;
            fill_cnt_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            count_q    <= count_d;
        end
    end

    // Stall is the only input allowed to reach an output without a register.
    assign sh_kick     = (state_q == ST_KICK);
    assign sh_done     = (state_q == ST_DONE);
    assign sh_busy     = (state_q != ST_READY);
    assign sh_shift_en = (state_q == ST_SHIFT) && !ss_stall;
    assign sh_count    = count_q;

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        count_d    = count_q;
        case (state_q)
            ST_READY: begin
                if (ss_start) begin
                    state_d = ST_KICK;
                end
            end
            ST_KICK: begin
                fill_cnt_d = '0;
                if (FILL_DELAY == 1) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (fill_cnt_q == FILL_LAST) begin
                    state_d    = ST_SHIFT;
                    fill_cnt_d = '0;
                end else begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (sh_shift_en) begin
                    if (count_q == COUNT_LAST) begin
                        state_d = ST_DONE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_READY;
            end
            default: begin
                state_d    = ST_READY;
                fill_cnt_d = '0;
                count_d    = '0;
            end
        endcase
    end

endmodule
